// File: rtl/imem_access_arbiter.sv
// Instruction-memory port arbiter: shares one synchronous-read RAM port between the
// fetch stage and the boot/debug loader, holding fetch off until the loader is done.
module imem_access_arbiter #(
    parameter int AW        = 11,
    parameter int MAX_BURST = 4,
    parameter bit BOOT_EN   = 1'b1
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    // Handshake (both requesters): a request is accepted in the cycle its gnt is high;
    // the requester holds req/addr/data stable until then, and read data follows one
    // cycle later on rvalid with no backpressure.
    input  logic                             i_f_req,
    input  logic [31:0]                      i_f_addr,
    output logic                             o_f_gnt,
    output logic                             o_f_rvalid,
    output logic [31:0]                      o_f_rdata,
    output logic                             o_f_misalign,
    input  logic                             i_l_req,
    input  logic                             i_l_we,
    input  logic [31:0]                      i_l_addr,
    input  logic [31:0]                      i_l_wdata,
    input  logic                             i_l_done,
    output logic                             o_l_gnt,
    output logic                             o_l_rvalid,
    output logic [31:0]                      o_l_rdata,
    output logic                             o_boot_done,
    output logic                             o_mem_en,
    output logic                             o_mem_we,
    output logic [AW-1:0]                    o_mem_addr,
    output logic [31:0]                      o_mem_wdata,
    input  logic [31:0]                      i_mem_rdata,
    output logic                             o_dbg_state,      // 0 = BOOT, 1 = RUN
    output logic [$clog2(MAX_BURST+1)-1:0]   o_dbg_starve_cnt
);

    localparam int            CW         = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(MAX_BURST);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          f_rvalid_q;
    logic          l_rvalid_q;
    logic          f_misalign_q;
    logic          boot_done_q;
    logic          f_gnt;
    logic          l_gnt;

    // Loader has priority in RUN; fetch wins once it has been denied MAX_BURST cycles in a row.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        f_gnt    = 1'b0;
        l_gnt    = 1'b0;
        case (state_q)
            ST_BOOT: begin
                l_gnt    = i_l_req;
                starve_d = '0;
                if (i_l_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_l_req && !(i_f_req && (starve_q == STARVE_MAX))) begin
                    l_gnt = 1'b1;
                end else if (i_f_req) begin
                    f_gnt = 1'b1;
                end
                if (!i_f_req || f_gnt) begin
                    starve_d = '0;
                end else if (starve_q != STARVE_MAX) begin
                    starve_d = starve_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        // Nothing reaches the memory while reset is held.
        if (i_reset) begin
            f_gnt = 1'b0;
            l_gnt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= BOOT_EN ? ST_BOOT : ST_RUN;
            starve_q     <= '0;
            f_rvalid_q   <= 1'b0;
            l_rvalid_q   <= 1'b0;
            f_misalign_q <= 1'b0;
            boot_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            f_rvalid_q   <= f_gnt;
            l_rvalid_q   <= l_gnt & ~i_l_we;
            f_misalign_q <= f_gnt & (|i_f_addr[1:0]);
            boot_done_q  <= (state_d == ST_RUN);
        end
    end

    // A read granted just before reset must not surface while reset is asserted.
    assign o_f_rvalid   = f_rvalid_q & ~i_reset;
    assign o_l_rvalid   = l_rvalid_q & ~i_reset;
    assign o_f_misalign = f_misalign_q & ~i_reset;
    assign o_f_rdata    = o_f_rvalid ? i_mem_rdata : '0;
    assign o_l_rdata    = o_l_rvalid ? i_mem_rdata : '0;

    assign o_f_gnt     = f_gnt;
    assign o_l_gnt     = l_gnt;
    assign o_boot_done = boot_done_q;

    assign o_mem_en    = f_gnt | l_gnt;
    assign o_mem_we    = l_gnt & i_l_we;
    assign o_mem_addr  = l_gnt ? i_l_addr[AW+1:2] : i_f_addr[AW+1:2];
    assign o_mem_wdata = i_l_wdata;

    assign o_dbg_state      = state_q;
    assign o_dbg_starve_cnt = starve_q;

    // Address bits above the memory size wrap; the loader's byte offset is ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_f_addr[31:AW+2], i_l_addr[31:AW+2], i_l_addr[1:0]};

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Bench for imem_access_arbiter: scenario tasks drive a behavioural 1-cycle RAM and
// check grants inline; read data is checked by a scoreboard against a shadow memory.
module tb_imem_access_arbiter;

    localparam int AW        = 11;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 2 ** AW;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_f_req = 1'b0;
    logic [31:0] i_f_addr = '0;
    logic        i_l_req = 1'b0;
    logic        i_l_we = 1'b0;
    logic [31:0] i_l_addr = '0;
    logic [31:0] i_l_wdata = '0;
    logic        i_l_done = 1'b0;
    logic [31:0] i_mem_rdata = '0;

    logic          o_f_gnt, o_f_rvalid, o_f_misalign;
    logic [31:0]   o_f_rdata;
    logic          o_l_gnt, o_l_rvalid;
    logic [31:0]   o_l_rdata;
    logic          o_boot_done, o_mem_en, o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic          o_dbg_state;
    logic [2:0]    o_dbg_starve_cnt;

    int errors = 0;
    int checks = 0;

    logic [31:0] ram    [DEPTH];
    logic [31:0] shadow [DEPTH];
    logic [32:0] f_exp_q [$];   // {misalign, data}
    logic [31:0] l_exp_q [$];

    imem_access_arbiter #(.AW(AW), .MAX_BURST(MAX_BURST), .BOOT_EN(1'b1)) dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_f_req          (i_f_req),
        .i_f_addr         (i_f_addr),
        .o_f_gnt          (o_f_gnt),
        .o_f_rvalid       (o_f_rvalid),
        .o_f_rdata        (o_f_rdata),
        .o_f_misalign     (o_f_misalign),
        .i_l_req          (i_l_req),
        .i_l_we           (i_l_we),
        .i_l_addr         (i_l_addr),
        .i_l_wdata        (i_l_wdata),
        .i_l_done         (i_l_done),
        .o_l_gnt          (o_l_gnt),
        .o_l_rvalid       (o_l_rvalid),
        .o_l_rdata        (o_l_rdata),
        .o_boot_done      (o_boot_done),
        .o_mem_en         (o_mem_en),
        .o_mem_we         (o_mem_we),
        .o_mem_addr       (o_mem_addr),
        .o_mem_wdata      (o_mem_wdata),
        .i_mem_rdata      (i_mem_rdata),
        .o_dbg_state      (o_dbg_state),
        .o_dbg_starve_cnt (o_dbg_starve_cnt)
    );

    // ---------------- clock / memory model ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_mem_en) begin
            if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
            else          i_mem_rdata     <= ram[o_mem_addr];
        end
    end

    // ---------------- scoreboard (sampled on the falling edge) ----------------
    always @(negedge clk) begin
        logic [32:0] fe;
        logic [31:0] le;
        if (o_f_rvalid) begin
            checks++;
            if (f_exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_f_unexpected: got rvalid=1 data=%h, expected no fetch rvalid", o_f_rdata);
            end else begin
                fe = f_exp_q.pop_front();
                if ({o_f_misalign, o_f_rdata} !== fe) begin
                    errors++;
                    $display("FAIL sb_f_data: got misalign=%b data=%h, expected misalign=%b data=%h",
                             o_f_misalign, o_f_rdata, fe[32], fe[31:0]);
                end
            end
        end else if (!i_reset) begin
            checks++;
            if (o_f_rdata !== 32'h0) begin
                errors++;
                $display("FAIL sb_f_idle_zero: got rdata=%h, expected 00000000", o_f_rdata);
            end
        end
        if (o_l_rvalid) begin
            checks++;
            if (l_exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_l_unexpected: got rvalid=1 data=%h, expected no loader rvalid", o_l_rdata);
            end else begin
                le = l_exp_q.pop_front();
                if (o_l_rdata !== le) begin
                    errors++;
                    $display("FAIL sb_l_data: got %h, expected %h", o_l_rdata, le);
                end
            end
        end else if (!i_reset) begin
            checks++;
            if (o_l_rdata !== 32'h0) begin
                errors++;
                $display("FAIL sb_l_idle_zero: got rdata=%h, expected 00000000", o_l_rdata);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; grants are sampled 3 units later.
    task automatic drive(input logic rst, input logic f_req, input logic [31:0] f_addr,
                         input logic l_req, input logic l_we, input logic [31:0] l_addr,
                         input logic [31:0] l_wdata, input logic l_done);
        @(posedge clk);
        #1;
        i_reset   = rst;
        i_f_req   = f_req;
        i_f_addr  = f_addr;
        i_l_req   = l_req;
        i_l_we    = l_we;
        i_l_addr  = l_addr;
        i_l_wdata = l_wdata;
        i_l_done  = l_done;
        #3;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // Records the effect of the grants the bench expects this cycle.
    task automatic sb_accept(input logic fg, input logic lg);
        if (lg) begin
            if (i_l_we) shadow[i_l_addr[AW+1:2]] = i_l_wdata;
            else        l_exp_q.push_back(shadow[i_l_addr[AW+1:2]]);
        end
        if (fg) f_exp_q.push_back({|i_f_addr[1:0], shadow[i_f_addr[AW+1:2]]});
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (o_f_gnt !== 1'b0 || o_mem_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: got f_gnt=%b mem_en=%b, expected 0 0", o_f_gnt, o_mem_en);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            checks++;
            if (o_f_gnt !== 1'b0 || o_mem_en !== 1'b0) begin
                errors++;
                $display("FAIL boot_fetch_blocked cyc %0d: got f_gnt=%b mem_en=%b, expected 0 0", i, o_f_gnt, o_mem_en);
            end
            checks++;
            if (o_boot_done !== 1'b0) begin
                errors++;
                $display("FAIL boot_done_low cyc %0d: got %b, expected 0", i, o_boot_done);
            end
        end
        checks++;
        if (o_dbg_state !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got %b, expected 0 (BOOT)", o_dbg_state);
        end
    endtask

    task automatic test_boot_load();
        // write 0x13 @0, fetch still requesting
        drive(1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 32'h0, 32'h0000_0013, 1'b0);
        checks++;
        if (o_l_gnt !== 1'b1 || o_f_gnt !== 1'b0 || o_mem_we !== 1'b1 || o_mem_addr !== 11'h000) begin
            errors++;
            $display("FAIL boot_write0: got l=%b f=%b we=%b addr=%h, expected 1 0 1 000", o_l_gnt, o_f_gnt, o_mem_we, o_mem_addr);
        end
        sb_accept(1'b0, 1'b1);
        // read-after-write to the same word
        drive(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (o_l_gnt !== 1'b1 || o_mem_we !== 1'b0 || o_mem_en !== 1'b1) begin
            errors++;
            $display("FAIL boot_read0: got l=%b we=%b en=%b, expected 1 0 1", o_l_gnt, o_mem_we, o_mem_en);
        end
        sb_accept(1'b0, 1'b1);
        // write @4 in the same cycle as the done pulse
        drive(1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 32'h4, 32'h0010_0093, 1'b1);
        checks++;
        if (o_l_gnt !== 1'b1 || o_f_gnt !== 1'b0 || o_boot_done !== 1'b0) begin
            errors++;
            $display("FAIL boot_write_done: got l=%b f=%b boot_done=%b, expected 1 0 0", o_l_gnt, o_f_gnt, o_boot_done);
        end
        sb_accept(1'b0, 1'b1);
        drive(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (o_boot_done !== 1'b1 || o_f_gnt !== 1'b1 || o_dbg_state !== 1'b1) begin
            errors++;
            $display("FAIL run_entry: got boot_done=%b f_gnt=%b state=%b, expected 1 1 1", o_boot_done, o_f_gnt, o_dbg_state);
        end
        sb_accept(1'b1, 1'b0);
        idle();
        checks++;
        if (o_f_rvalid !== 1'b1 || o_f_rdata !== 32'h0010_0093) begin
            errors++;
            $display("FAIL first_fetch: got rvalid=%b data=%h, expected 1 00100093", o_f_rvalid, o_f_rdata);
        end
    endtask

    task automatic test_priority();
        logic        el;
        logic [31:0] la;
        idle();
        for (int c = 0; c < 15; c++) begin
            la = 32'($urandom_range(16, 31)) << 2;
            drive(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, la, 32'h0, 1'b0);
            el = ((c % 5) != 4);
            checks++;
            if (o_l_gnt !== el || o_f_gnt !== !el) begin
                errors++;
                $display("FAIL prio_pattern cyc %0d: got l=%b f=%b, expected l=%b f=%b", c, o_l_gnt, o_f_gnt, el, !el);
            end
            checks++;
            if (o_dbg_starve_cnt !== 3'(c % 5)) begin
                errors++;
                $display("FAIL prio_starve cyc %0d: got %0d, expected %0d", c, o_dbg_starve_cnt, c % 5);
            end
            sb_accept(!el, el);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 32'(k * 4), 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            checks++;
            if (o_f_gnt !== 1'b1 || o_f_rvalid !== (k != 0)) begin
                errors++;
                $display("FAIL b2b cyc %0d: got gnt=%b rvalid=%b, expected 1 %b", k, o_f_gnt, o_f_rvalid, k != 0);
            end
            sb_accept(1'b1, 1'b0);
        end
        idle();
        checks++;
        if (o_f_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_tail: got rvalid=%b, expected 1", o_f_rvalid);
        end
        idle();
        checks++;
        if (o_f_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got rvalid=%b, expected 0", o_f_rvalid);
        end
    endtask

    task automatic test_wrap_misalign();
        drive(1'b0, 1'b1, 32'h0000_2002, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (o_f_gnt !== 1'b1 || o_mem_addr !== 11'h000) begin
            errors++;
            $display("FAIL wrap_addr: got gnt=%b addr=%h, expected 1 000", o_f_gnt, o_mem_addr);
        end
        sb_accept(1'b1, 1'b0);
        idle();
        checks++;
        if (o_f_rvalid !== 1'b1 || o_f_misalign !== 1'b1) begin
            errors++;
            $display("FAIL misalign_flag: got rvalid=%b misalign=%b, expected 1 1", o_f_rvalid, o_f_misalign);
        end
    endtask

    task automatic test_random_mixed();
        int          cnt;
        logic        fr, lr, lw, ld, ef, el;
        logic [31:0] fa, la, wd;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            fr = 1'($urandom_range(0, 1));
            lr = 1'($urandom_range(0, 1));
            lw = 1'($urandom_range(0, 1));
            ld = ($urandom_range(0, 7) == 0);
            fa = 32'($urandom_range(0, 63));
            la = 32'($urandom_range(0, 15)) << 2;
            wd = $urandom();
            drive(1'b0, fr, fa, lr, lw, la, wd, ld);
            el = lr && !(fr && cnt == MAX_BURST);
            ef = fr && !el;
            checks++;
            if (o_f_gnt !== ef || o_l_gnt !== el || o_mem_we !== (el && lw)) begin
                errors++;
                $display("FAIL mixed_gnt cyc %0d: got f=%b l=%b we=%b, expected f=%b l=%b we=%b",
                         c, o_f_gnt, o_l_gnt, o_mem_we, ef, el, el && lw);
            end
            checks++;
            if (o_dbg_starve_cnt !== 3'(cnt) || o_boot_done !== 1'b1) begin
                errors++;
                $display("FAIL mixed_state cyc %0d: got starve=%0d boot_done=%b, expected %0d 1",
                         c, o_dbg_starve_cnt, o_boot_done, cnt);
            end
            sb_accept(ef, el);
            if (!fr || ef) cnt = 0;
            else if (cnt < MAX_BURST) cnt++;
        end
        idle();
        idle();
    endtask

    task automatic test_reset_cancel();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        checks++;
        if (o_l_gnt !== 1'b1) begin
            errors++;
            $display("FAIL cancel_gnt: got l_gnt=%b, expected 1", o_l_gnt);
        end
        // no scoreboard entry: reset next cycle swallows this read
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (o_l_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cancel_rvalid: got %b, expected 0", o_l_rvalid);
        end
        drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (o_dbg_state !== 1'b0 || o_boot_done !== 1'b0 || o_f_gnt !== 1'b0 || o_l_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cancel_state: got state=%b boot_done=%b f_gnt=%b l_rvalid=%b, expected 0 0 0 0",
                     o_dbg_state, o_boot_done, o_f_gnt, o_l_rvalid);
        end
        idle();
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]    = 32'h1000_0000 + 32'(i);
            shadow[i] = 32'h1000_0000 + 32'(i);
        end
        test_reset();
        test_boot_load();
        test_priority();
        test_back_to_back();
        test_wrap_misalign();
        test_random_mixed();
        test_reset_cancel();
        idle();
        idle();
        checks++;
        if (f_exp_q.size() != 0 || l_exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d fetch and %0d loader results outstanding, expected 0 0",
                     f_exp_q.size(), l_exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
